cordic_sqrt_hs: RTL and testbench

Parametrised successor of the fixed-width square-root block. It computes an unsigned integer square root by the digit-by-digit (non-restoring) method, with a configurable number of root bits resolved per cycle and a runtime fractional/integer mode. The block uses a valid/ready handshake on both sides, outputs the remainder, and passes a user tag through unchanged. It sits between a producer and a consumer of fixed-point magnitudes in the datapath.

---
 rtl/cordic_sqrt_hs.sv | 139 +++++++++++++
 tb/tb_cordic_sqrt_hs.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sqrt_hs.sv
// Iterative digit-by-digit (non-restoring) unsigned square root with valid/ready handshakes,
// UNROLL root bits per clock, fractional/integer radicand mode and a pass-through tag.
module cordic_sqrt_hs #(
    parameter int DSIZE  = 16,
    parameter int UNROLL = 1,
    parameter int TSIZE  = 4
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_frac,
    input  logic [DSIZE-1:0] d,
    input  logic [TSIZE-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] q,
    output logic [DSIZE:0]   rem,
    output logic [TSIZE-1:0] out_tag
);

    localparam int ITER = DSIZE / UNROLL;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int RW   = DSIZE + 2;
    localparam int XW   = 2 * DSIZE;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state, state_nx;
    logic                   accept, finish;
    logic [CW-1:0]          cnt;
    logic [XW-1:0]          rad, rad_nx;
    logic [DSIZE-1:0]       root, root_nx;
    logic signed [RW-1:0]   prem, prem_nx, shifted;
    logic [TSIZE-1:0]       tag_hold;

    // A negative final partial remainder is brought back to R - q*q by adding 2q+1.
    function automatic logic signed [RW-1:0] fix_rem(input logic signed [RW-1:0] r,
                                                     input logic [DSIZE-1:0] root_f);
        if (r[RW-1])
            return r + $signed({1'b0, root_f, 1'b1});
        return r;
    endfunction

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (accept)
                cnt <= CW'(ITER - 1);
            else if (state == BUSY && cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    finish   = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        accept   = 1'b1;
                        state_nx = BUSY;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Iteration stage: UNROLL radicand digit pairs consumed MSB first per clock.
    always_comb begin
        rad_nx  = rad;
        root_nx = root;
        prem_nx = prem;
        shifted = '0;
        for (int k = 0; k < UNROLL; k++) begin
            shifted = $signed({prem_nx[RW-3:0], rad_nx[XW-1 -: 2]});
            if (prem_nx[RW-1])
                prem_nx = shifted + $signed({root_nx, 2'b11});
            else
                prem_nx = shifted - $signed({root_nx, 2'b01});
            root_nx = {root_nx[DSIZE-2:0], ~prem_nx[RW-1]};
            rad_nx  = rad_nx << 2;
        end
        if (cnt == '0)
            prem_nx = fix_rem(prem_nx, root_nx);
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            rad      <= in_frac ? {d, {DSIZE{1'b0}}} : {{DSIZE{1'b0}}, d};
            root     <= '0;
            prem     <= '0;
            tag_hold <= in_tag;
        end else if (state == BUSY) begin
            rad  <= rad_nx;
            root <= root_nx;
            prem <= prem_nx;
        end
    end

    // Result stage: loaded only on the last BUSY cycle, held through DONE.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            q       <= '0;
            rem     <= '0;
            out_tag <= '0;
        end else if (finish) begin
            q       <= root_nx;
            rem     <= prem_nx[DSIZE:0];
            out_tag <= tag_hold;
        end
    end

endmodule

// File: tb/tb_cordic_sqrt_hs.sv
// Scoreboard bench for cordic_sqrt_hs: three instances (UNROLL 1, 2, 4) checked against
// an integer-corrected real sqrt model, with handshake, backpressure and reset scenarios.
module tb_cordic_sqrt_hs;

    typedef struct {
        logic [15:0] q;
        logic [16:0] rem;
        logic [3:0]  tag;
        int          acc;
    } exp_t;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid_v  [3];
    logic        in_ready_v  [3];
    logic        in_frac_v   [3];
    logic [15:0] d_v         [3];
    logic [3:0]  in_tag_v    [3];
    logic        out_valid_v [3];
    logic        out_ready_v [3];
    logic [15:0] q_v         [3];
    logic [16:0] rem_v       [3];
    logic [3:0]  out_tag_v   [3];

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    cordic_sqrt_hs #(.DSIZE(16), .UNROLL(1), .TSIZE(4)) u_dut1 (
        .clock(clock), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_frac(in_frac_v[0]), .d(d_v[0]), .in_tag(in_tag_v[0]), .out_valid(out_valid_v[0]),
        .out_ready(out_ready_v[0]), .q(q_v[0]), .rem(rem_v[0]), .out_tag(out_tag_v[0]));

    cordic_sqrt_hs #(.DSIZE(16), .UNROLL(2), .TSIZE(4)) u_dut2 (
        .clock(clock), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_frac(in_frac_v[1]), .d(d_v[1]), .in_tag(in_tag_v[1]), .out_valid(out_valid_v[1]),
        .out_ready(out_ready_v[1]), .q(q_v[1]), .rem(rem_v[1]), .out_tag(out_tag_v[1]));

    cordic_sqrt_hs #(.DSIZE(16), .UNROLL(4), .TSIZE(4)) u_dut4 (
        .clock(clock), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .in_frac(in_frac_v[2]), .d(d_v[2]), .in_tag(in_tag_v[2]), .out_valid(out_valid_v[2]),
        .out_ready(out_ready_v[2]), .q(q_v[2]), .rem(rem_v[2]), .out_tag(out_tag_v[2]));

    function automatic exp_t model(input logic frac, input logic [15:0] dv,
                                   input logic [3:0] tg, input int acc);
        exp_t   e;
        longint r;
        longint qq;
        r  = frac ? (longint'(dv) << 16) : longint'(dv);
        qq = longint'($floor($sqrt(real'(r))));
        while ((qq + 1) * (qq + 1) <= r) qq++;
        while (qq * qq > r) qq--;
        e.q   = qq[15:0];
        e.rem = 17'(r - qq * qq);
        e.tag = tg;
        e.acc = acc;
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clock);
        for (int u = 0; u < 3; u++) begin
            n_vec++;
            if (out_valid_v[u] !== 1'b0) begin
                n_err++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", u, out_valid_v[u]);
            end
            n_vec++;
            if (q_v[u] !== 16'd0) begin
                n_err++; $display("FAIL reset_q[%0d]: got %0d expected 0", u, q_v[u]);
            end
            n_vec++;
            if (rem_v[u] !== 17'd0) begin
                n_err++; $display("FAIL reset_rem[%0d]: got %0d expected 0", u, rem_v[u]);
            end
            n_vec++;
            if (out_tag_v[u] !== 4'd0) begin
                n_err++; $display("FAIL reset_tag[%0d]: got %0d expected 0", u, out_tag_v[u]);
            end
        end
        rst_n = 1'b1;
        #1;
        for (int u = 0; u < 3; u++) begin
            n_vec++;
            if (in_ready_v[u] !== 1'b1) begin
                n_err++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", u, in_ready_v[u]);
            end
        end
    endtask

    task automatic test_directed();
        bit       fr [7] = '{1, 1, 1, 1, 0, 0, 0};
        int       dd [7] = '{58982, 16384, 65535, 0, 0, 65535, 144};
        int       tg [7] = '{5, 1, 2, 3, 4, 6, 7};
        int       eq [7] = '{62172, 32768, 65535, 0, 0, 255, 12};
        int       er [7] = '{86768, 0, 65535, 0, 0, 510, 0};
        exp_t     e;
        bit       got;
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            in_frac_v[0]   = fr[i];
            d_v[0]         = 16'(dd[i]);
            in_tag_v[0]    = 4'(tg[i]);
            in_valid_v[0]  = 1'b1;
            out_ready_v[0] = 1'b1;
            #1;
            n_vec++;
            if (in_ready_v[0] !== 1'b1) begin
                n_err++; $display("FAIL directed_in_ready[%0d]: got %b expected 1", i, in_ready_v[0]);
            end
            e.q = 16'(eq[i]); e.rem = 17'(er[i]); e.tag = 4'(tg[i]); e.acc = cyc + 1;
            sb.push_back(e);
            @(negedge clock);
            in_valid_v[0] = 1'b0;
            in_frac_v[0]  = ~fr[i];
            d_v[0]        = 16'($urandom);
            got = 1'b0;
            for (int w = 0; w < 40 && !got; w++) begin
                if (out_valid_v[0] === 1'b1) got = 1'b1;
                else @(negedge clock);
            end
            e = sb.pop_front();
            n_vec++;
            if (!got) begin
                n_err++; $display("FAIL directed_timeout[%0d]: got no out_valid expected one within 40 cycles", i);
            end else begin
                if (cyc - e.acc != 16) begin
                    n_err++; $display("FAIL directed_latency[%0d]: got %0d expected 16", i, cyc - e.acc);
                end
                n_vec++;
                if (q_v[0] !== e.q) begin
                    n_err++; $display("FAIL directed_q[%0d]: got %0d expected %0d", i, q_v[0], e.q);
                end
                n_vec++;
                if (rem_v[0] !== e.rem) begin
                    n_err++; $display("FAIL directed_rem[%0d]: got %0d expected %0d", i, rem_v[0], e.rem);
                end
                n_vec++;
                if (out_tag_v[0] !== e.tag) begin
                    n_err++; $display("FAIL directed_tag[%0d]: got %0d expected %0d", i, out_tag_v[0], e.tag);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        bit   got;
        @(negedge clock);
        out_ready_v[0] = 1'b0;
        in_frac_v[0] = 1'b1; d_v[0] = 16'd58982; in_tag_v[0] = 4'd9; in_valid_v[0] = 1'b1;
        #1;
        sb.push_back(model(1'b1, 16'd58982, 4'd9, cyc + 1));
        @(negedge clock);
        in_valid_v[0] = 1'b0;
        got = 1'b0;
        for (int w = 0; w < 40 && !got; w++) begin
            if (out_valid_v[0] === 1'b1) got = 1'b1;
            else @(negedge clock);
        end
        n_vec++;
        if (!got) begin
            n_err++; $display("FAIL bp_timeout: got no out_valid expected one within 40 cycles");
            sb.delete();
            out_ready_v[0] = 1'b1;
            return;
        end
        if (cyc - sb[0].acc != 16) begin
            n_err++; $display("FAIL bp_latency: got %0d expected 16", cyc - sb[0].acc);
        end
        in_valid_v[0] = 1'b1; in_frac_v[0] = 1'b0; d_v[0] = 16'd144; in_tag_v[0] = 4'd3;
        for (int c = 0; c < 10; c++) begin
            #1;
            n_vec++;
            if (out_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0) begin
                n_err++; $display("FAIL bp_hold_hs[%0d]: got valid=%b ready=%b expected 1/0", c, out_valid_v[0], in_ready_v[0]);
            end
            n_vec++;
            if (q_v[0] !== sb[0].q || rem_v[0] !== sb[0].rem || out_tag_v[0] !== sb[0].tag) begin
                n_err++; $display("FAIL bp_hold_data[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", c,
                                  q_v[0], rem_v[0], out_tag_v[0], sb[0].q, sb[0].rem, sb[0].tag);
            end
            @(negedge clock);
        end
        out_ready_v[0] = 1'b1;
        #1;
        n_vec++;
        if (in_ready_v[0] !== 1'b1) begin
            n_err++; $display("FAIL bp_handoff_ready: got %b expected 1", in_ready_v[0]);
        end
        e = sb.pop_front();
        sb.push_back(model(1'b0, 16'd144, 4'd3, cyc + 1));
        @(negedge clock);
        in_valid_v[0] = 1'b0;
        d_v[0] = 16'hFFFF;
        #1;
        n_vec++;
        if (out_valid_v[0] !== 1'b0) begin
            n_err++; $display("FAIL bp_handoff_busy: got out_valid=%b expected 0", out_valid_v[0]);
        end
        got = 1'b0;
        for (int w = 0; w < 40 && !got; w++) begin
            if (out_valid_v[0] === 1'b1) got = 1'b1;
            else @(negedge clock);
        end
        e = sb.pop_front();
        n_vec++;
        if (!got) begin
            n_err++; $display("FAIL bp2_timeout: got no out_valid expected one within 40 cycles");
        end else begin
            if (cyc - e.acc != 16) begin
                n_err++; $display("FAIL bp2_latency: got %0d expected 16", cyc - e.acc);
            end
            n_vec++;
            if (q_v[0] !== e.q || rem_v[0] !== e.rem || out_tag_v[0] !== e.tag) begin
                n_err++; $display("FAIL bp2_result: got %0d/%0d/%0d expected %0d/%0d/%0d",
                                  q_v[0], rem_v[0], out_tag_v[0], e.q, e.rem, e.tag);
            end
        end
    endtask

    task automatic test_sweep(input int u);
        int   it;
        int   sent;
        int   got;
        int   guard;
        int   t;
        bit   hold;
        logic prev_ov;
        exp_t e;
        it = 16 >> u;
        sent = 0; got = 0; guard = 0; hold = 1'b0; prev_ov = 1'b0;
        sb.delete();
        @(negedge clock);
        while (got < 9 && guard < 3000) begin
            out_ready_v[u] = ($urandom_range(0, 3) != 0);
            if (!hold) begin
                if (sent < 9 && $urandom_range(0, 1) == 1) begin
                    hold = 1'b1;
                    t = 9 - sent;
                    d_v[u] = 16'((t * 65536) / 10);
                    in_frac_v[u] = 1'b1;
                    in_tag_v[u] = 4'(t);
                    in_valid_v[u] = 1'b1;
                end else begin
                    in_valid_v[u] = 1'b0;
                    d_v[u] = 16'($urandom);
                    in_frac_v[u] = 1'($urandom_range(0, 1));
                    in_tag_v[u] = 4'($urandom);
                end
            end
            #1;
            if (out_valid_v[u] === 1'b1 && prev_ov !== 1'b1) begin
                n_vec++;
                if (sb.size() == 0 || cyc - sb[0].acc != it) begin
                    n_err++; $display("FAIL sweep_latency[u%0d]: got %0d expected %0d", u,
                                      (sb.size() == 0) ? -1 : cyc - sb[0].acc, it);
                end
            end
            prev_ov = out_valid_v[u];
            if (out_valid_v[u] === 1'b1 && out_ready_v[u]) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL sweep_unexpected[u%0d]: got result q=%0d expected none", u, q_v[u]);
                end else begin
                    e = sb.pop_front();
                    got++;
                    if (q_v[u] !== e.q || rem_v[u] !== e.rem || out_tag_v[u] !== e.tag) begin
                        n_err++; $display("FAIL sweep_result[u%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", u,
                                          q_v[u], rem_v[u], out_tag_v[u], e.q, e.rem, e.tag);
                    end
                    n_vec++;
                    if (int'(rem_v[u]) > 2 * int'(q_v[u])) begin
                        n_err++; $display("FAIL sweep_rem_bound[u%0d]: got rem %0d expected <= %0d", u, rem_v[u], 2 * q_v[u]);
                    end
                end
            end
            if (in_valid_v[u] === 1'b1 && in_ready_v[u] === 1'b1) begin
                sb.push_back(model(1'b1, d_v[u], in_tag_v[u], cyc + 1));
                hold = 1'b0;
                sent++;
            end
            @(negedge clock);
            guard++;
        end
        in_valid_v[u] = 1'b0;
        out_ready_v[u] = 1'b1;
        n_vec++;
        if (got != 9) begin
            n_err++; $display("FAIL sweep_count[u%0d]: got %0d results expected 9", u, got);
        end
    endtask

    task automatic test_reset_mid();
        logic stale;
        @(negedge clock);
        in_frac_v[0] = 1'b1; d_v[0] = 16'd58982; in_tag_v[0] = 4'd5;
        in_valid_v[0] = 1'b1; out_ready_v[0] = 1'b1;
        #1;
        n_vec++;
        if (in_ready_v[0] !== 1'b1) begin
            n_err++; $display("FAIL rmid_accept: got in_ready=%b expected 1", in_ready_v[0]);
        end
        @(negedge clock);
        in_valid_v[0] = 1'b0;
        repeat (6) @(negedge clock);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid_v[0] !== 1'b0) begin
            n_err++; $display("FAIL rmid_out_valid: got %b expected 0", out_valid_v[0]);
        end
        n_vec++;
        if (q_v[0] !== 16'd0 || rem_v[0] !== 17'd0 || out_tag_v[0] !== 4'd0) begin
            n_err++; $display("FAIL rmid_clear: got %0d/%0d/%0d expected 0/0/0", q_v[0], rem_v[0], out_tag_v[0]);
        end
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0) begin
            n_err++; $display("FAIL rmid_release: got ready=%b valid=%b expected 1/0", in_ready_v[0], out_valid_v[0]);
        end
        stale = 1'b0;
        repeat (30) begin
            @(negedge clock);
            stale = stale | out_valid_v[0];
        end
        n_vec++;
        if (stale !== 1'b0) begin
            n_err++; $display("FAIL rmid_stale: got out_valid=%b after release expected 0", stale);
        end
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            in_valid_v[u] = 1'b0; in_frac_v[u] = 1'b0; d_v[u] = '0;
            in_tag_v[u] = '0; out_ready_v[u] = 1'b1;
        end
        test_reset();
        test_directed();
        test_backpressure();
        test_sweep(0);
        test_sweep(1);
        test_sweep(2);
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
